// File: rtl/inst_assembler.sv
// -----------------------------------------------------------------------------
// inst_assembler
//
// Sequential MIPS instruction assembler. Each accepted request (mnemonic index
// plus rs/rt/rd/imm fields) is encoded into a 32-bit MIPS word and written into
// instruction memory at base_addr + count through a one-entry output register
// that honours write-port back-pressure.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   start, base_addr         program start pulse (IDLE only) and first address
//   req_valid / req_ready    request handshake
//   req_mnem                 mnemonic index 0..53 (54..63 illegal)
//   req_rs/rt/rd, req_imm    instruction fields
//   req_last                 final instruction of the program
//   imem_we/addr/wdata       IMEM write port (strobe held while imem_stall)
//   imem_stall               IMEM not taking the write this cycle
//   busy, done               activity flag and one-cycle completion pulse
//   inst_count               words written since start
//   err_ill, err_ovf         sticky illegal-mnemonic / capacity-overflow flags
//   checksum                 XOR of all written words (optional)
//
// Optional feature: define INST_ASM_CHECKSUM_EN to add the checksum output.
// -----------------------------------------------------------------------------
module inst_assembler #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_mnem,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [25:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   inst_count,
    output logic              err_ill,
    output logic              err_ovf
`ifdef INST_ASM_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    // Mnemonic indices, in request encoding order.
    typedef enum logic [5:0] {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_ADDI, M_ADDIU,
        M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE, M_SLTI, M_SLTIU,
        M_LUI, M_J, M_JAL, M_CLZ, M_DIVU, M_ERET, M_JALR, M_LB, M_LBU, M_LHU,
        M_SB, M_SH, M_LH, M_MFC0, M_MFHI, M_MFLO, M_MTC0, M_MTHI, M_MTLO,
        M_MUL, M_MULTU, M_SYSCALL, M_TEQ, M_BGEZ, M_BREAK, M_DIV
    } mnem_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_COP0     = 6'b010000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;

    localparam logic [ADDR_W:0] CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [31:0] pack_r(input logic [5:0] op,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [4:0] sh,
                                           input logic [5:0] func);
        return {op, rs, rt, rd, sh, func};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_ill_q, err_ill_d;
    logic                err_ovf_q, err_ovf_d;
`ifdef INST_ASM_CHECKSUM_EN
    logic [31:0]         checksum_q, checksum_d;
`endif

    // -------------------------------------------------------------------------
    // Encoder
    // -------------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_legal;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm16;

    assign rs    = req_rs;
    assign rt    = req_rt;
    assign rd    = req_rd;
    assign sh    = req_imm[4:0];
    assign imm16 = req_imm[15:0];

    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (req_mnem)
            // SPECIAL group
            M_ADD:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100000);
            M_ADDU:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100001);
            M_SUB:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100010);
            M_SUBU:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100011);
            M_AND:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100100);
            M_OR:      enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100101);
            M_XOR:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100110);
            M_NOR:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b100111);
            M_SLT:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b101010);
            M_SLTU:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b101011);
            // Immediate shifts carry their shift amount in imm[4:0].
            M_SLL:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, sh,   6'b000000);
            M_SRL:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, sh,   6'b000010);
            M_SRA:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, sh,   6'b000011);
            M_SLLV:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b000100);
            M_SRLV:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b000110);
            M_SRAV:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b000111);
            M_JR:      enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b001000);
            M_JALR:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b001001);
            M_SYSCALL: enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b001100);
            M_BREAK:   enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b001101);
            M_MFHI:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b010000);
            M_MTHI:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b010001);
            M_MFLO:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b010010);
            M_MTLO:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b010011);
            M_MULTU:   enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b011001);
            M_DIV:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b011010);
            M_DIVU:    enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b011011);
            M_TEQ:     enc_word = pack_r(OP_SPECIAL, rs, rt, rd, 5'd0, 6'b110100);
            // SPECIAL2 group
            M_CLZ:     enc_word = pack_r(OP_SPECIAL2, rs, rt, rd, 5'd0, 6'b100000);
            M_MUL:     enc_word = pack_r(OP_SPECIAL2, rs, rt, rd, 5'd0, 6'b000010);
            // COP0 group: the rs slot selects MF/MT, ERET is a fixed word.
            M_MFC0:    enc_word = pack_r(OP_COP0, 5'b00000, rt, rd, 5'd0, 6'b000000);
            M_MTC0:    enc_word = pack_r(OP_COP0, 5'b00100, rt, rd, 5'd0, 6'b000000);
            M_ERET:    enc_word = 32'h4200_0018;
            // I-type
            M_ADDI:    enc_word = pack_i(6'b001000, rs, rt, imm16);
            M_ADDIU:   enc_word = pack_i(6'b001001, rs, rt, imm16);
            M_SLTI:    enc_word = pack_i(6'b001010, rs, rt, imm16);
            M_SLTIU:   enc_word = pack_i(6'b001011, rs, rt, imm16);
            M_ANDI:    enc_word = pack_i(6'b001100, rs, rt, imm16);
            M_ORI:     enc_word = pack_i(6'b001101, rs, rt, imm16);
            M_XORI:    enc_word = pack_i(6'b001110, rs, rt, imm16);
            M_LUI:     enc_word = pack_i(6'b001111, 5'd0, rt, imm16);
            M_BEQ:     enc_word = pack_i(6'b000100, rs, rt, imm16);
            M_BNE:     enc_word = pack_i(6'b000101, rs, rt, imm16);
            M_LB:      enc_word = pack_i(6'b100000, rs, rt, imm16);
            M_LH:      enc_word = pack_i(6'b100001, rs, rt, imm16);
            M_LW:      enc_word = pack_i(6'b100011, rs, rt, imm16);
            M_LBU:     enc_word = pack_i(6'b100100, rs, rt, imm16);
            M_LHU:     enc_word = pack_i(6'b100101, rs, rt, imm16);
            M_SB:      enc_word = pack_i(6'b101000, rs, rt, imm16);
            M_SH:      enc_word = pack_i(6'b101001, rs, rt, imm16);
            M_SW:      enc_word = pack_i(6'b101011, rs, rt, imm16);
            // REGIMM: the rt slot selects BGEZ.
            M_BGEZ:    enc_word = pack_i(OP_REGIMM, rs, 5'b00001, imm16);
            // J-type
            M_J:       enc_word = {6'b000010, req_imm};
            M_JAL:     enc_word = {6'b000011, req_imm};
            default:   enc_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake and datapath control
    // -------------------------------------------------------------------------
    logic            accept;
    logic            complete;
    logic            cap_reached;
    logic            write_new;
    logic [ADDR_W:0] count_pend;

    assign req_ready = (state_q == S_RUN) && (!out_valid_q || !imem_stall);
    assign accept    = req_valid && req_ready;
    assign complete  = out_valid_q && !imem_stall;

    // Words already committed plus the one sitting in the output register.
    // A request is only accepted while that register is empty or draining, so
    // this is the slot number the new word will occupy.
    assign count_pend  = count_q + {{ADDR_W{1'b0}}, out_valid_q};
    assign cap_reached = (count_pend == CAPACITY);
    assign write_new   = accept && enc_legal && !cap_reached;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        base_d      = base_q;
        count_d     = count_q;
        err_ill_d   = err_ill_q;
        err_ovf_d   = err_ovf_q;
`ifdef INST_ASM_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        if (complete) begin
            out_valid_d = 1'b0;
            count_d     = count_q + COUNT_ONE;
`ifdef INST_ASM_CHECKSUM_EN
            checksum_d  = checksum_q ^ out_data_q;
`endif
        end

        // Reload on the same edge as a completion keeps 1 word/cycle.
        if (write_new) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_word;
            out_addr_d  = base_q + count_pend[ADDR_W-1:0];
        end

        if (accept && !enc_legal) begin
            err_ill_d = 1'b1;
        end
        if (accept && enc_legal && cap_reached) begin
            err_ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    base_d     = base_addr;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_ovf_d  = 1'b0;
`ifdef INST_ASM_CHECKSUM_EN
                    checksum_d = 32'h0;
`endif
                end
            end
            S_RUN: begin
                // An illegal last request still ends the program.
                if (accept && req_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register here samples the
        // pre-edge values of the others regardless of statement order.
        if (rst) begin
            // NOTE: the output data/address register is reset as well, since
            // its contents appear directly on the IMEM port after reset.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= 32'h0;
            base_q      <= '0;
            count_q     <= '0;
            err_ill_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
`ifdef INST_ASM_CHECKSUM_EN
            checksum_q  <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            base_q      <= base_d;
            count_q     <= count_d;
            err_ill_q   <= err_ill_d;
            err_ovf_q   <= err_ovf_d;
`ifdef INST_ASM_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_we    = out_valid_q;
    assign imem_addr  = out_addr_q;
    assign imem_wdata = out_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign inst_count = count_q;
    assign err_ill    = err_ill_q;
    assign err_ovf    = err_ovf_q;
`ifdef INST_ASM_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: doc/inst_assembler.md
# inst_assembler

Sequential MIPS instruction assembler that is the inverse of the CPU's instruction decoder. It accepts one mnemonic index plus register and immediate fields per handshake and encodes each into a 32-bit MIPS word. Words are written sequentially into instruction memory through a back-pressured write port. It sits beside IMEM on the bench/boot path, so self-test programs are loaded as field tuples instead of hand-packed hex, and every word it emits decodes back to the requested mnemonic.

## Interface
Parameters:
- ADDR_W, 10, word-address width of IMEM write port; program capacity 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse in IDLE; loads base_addr, clears count/errors, enters RUN.
- base_addr  in  ADDR_W  first IMEM word address of the program.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on cycle where req_valid && req_ready.
- req_mnem  in  6  mnemonic index 0..53; 54..63 illegal.
- req_rs / req_rt / req_rd  in  5 each  register fields.
- req_imm  in  26  imm26 for J/JAL; imm[15:0] for I-type; imm[4:0] = shamt for SLL/SRL/SRA.
- req_last  in  1  marks final instruction of program.
- imem_we  out  1  write strobe, held while imem_stall.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- imem_stall  in  1  IMEM not taking write this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after final write completes.
- inst_count  out  ADDR_W+1  words written since start.
- err_ill  out  1  sticky: an illegal mnemonic was received.
- err_ovf  out  1  sticky: program exceeded capacity.

## Operation
- Mnemonic index order: 0 ADD,1 ADDU,2 SUB,3 SUBU,4 AND,5 OR,6 XOR,7 NOR,8 SLT,9 SLTU,10 SLL,11 SRL,12 SRA,13 SLLV,14 SRLV,15 SRAV,16 JR,17 ADDI,18 ADDIU,19 ANDI,20 ORI,21 XORI,22 LW,23 SW,24 BEQ,25 BNE,26 SLTI,27 SLTIU,28 LUI,29 J,30 JAL,31 CLZ,32 DIVU,33 ERET,34 JALR,35 LB,36 LBU,37 LHU,38 SB,39 SH,40 LH,41 MFC0,42 MFHI,43 MFLO,44 MTC0,45 MTHI,46 MTLO,47 MUL,48 MULTU,49 SYSCALL,50 TEQ,51 BGEZ,52 BREAK,53 DIV.
- SPECIAL (op 000000) group: {op,rs,rt,rd,shamt,func}. shamt = imm[4:0] for SLL/SRL/SRA, else 0. func per MIPS32: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000, JALR 001001, SYSCALL 001100, BREAK 001101, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULTU 011001, DIV 011010, DIVU 011011, TEQ 110100.
- SPECIAL2 (op 011100) group: CLZ func 100000; MUL func 000010; fields rs,rt,rd, shamt 0.
- COP0 (op 010000) group, func 000000 except ERET. MFC0: rs forced 00000. MTC0: rs forced 00100. ERET: word is fixed 0x42000018.
- I-type {op,rs,rt,imm[15:0]}, with op: ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111 (rs forced 0), BEQ 000100, BNE 000101, LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011. BGEZ: op 000001, rt forced 00001.
- J-type {op,imm26}: J op 000010, JAL op 000011.
- FSM states:
  - IDLE: start → RUN.
  - RUN: accepted req_last → DRAIN.
  - DRAIN: output register empty → DONE.
  - DONE: next cycle → IDLE.
- Output register is a one-entry stage. It loads on acceptance and empties when imem_we && !imem_stall. req_ready = (state==RUN) && (!out_valid || !imem_stall).
- Illegal mnemonic: accepted but no word is written; err_ill set; count and address unchanged. req_last on an illegal request still ends the program.
- Address = base_addr + count, modulo 2^ADDR_W. Once count == 2^ADDR_W, further legal requests are accepted and discarded, and err_ovf is set.
- start outside IDLE is ignored.
- rst mid-program: all state cleared next edge; any pending write is dropped.

## Timing
- Reset values: req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, inst_count 0, err_ill 0, err_ovf 0; state IDLE.
- start at edge N → busy=1 and req_ready=1 from N+1.
- Acceptance at edge N → imem_we=1 with valid addr/data from N+1. The strobe is held while imem_stall=1. inst_count increments on the completing edge.
- Throughput is 1 word/cycle with no stall.
- Acceptance and completion on the same edge: the register reloads and imem_we stays high.
- done pulses exactly one cycle, one cycle after the last write completes.

## Configuration
- INST_ASM_CHECKSUM_EN defined:
  - Adds output checksum [31:0], reset/start value 0.
  - checksum ^= imem_wdata on every completed write.
  - Value is final when done pulses.
- Undefined: no checksum port or logic.

## Test plan
- Reset, start base 0x010, ADD rs=1 rt=2 rd=3 last → one write, addr 0x010, data 0x00221820; done one cycle later; inst_count 1.
- Stream ADDI r1,r0,0x7FFF; J 0x0100000; ERET; BGEZ rs=4 imm 0xFFFE with no stall → 4 consecutive writes: 0x20017FFF, 0x08100000, 0x42000018, 0x0481FFFE.
- imem_stall held high 3 cycles on first of two back-to-back reqs → imem_we/addr/data held stable; req_ready=0 while the register is full; both words land in order.
- req_mnem 60 between two legal reqs → err_ill=1; the legal words land at consecutive addresses; inst_count 2.
- ADDR_W=2 build, 5 legal reqs → 4 writes, err_ovf=1 after the fifth, no fifth write.
- rst asserted while imem_stall holds a pending word → next cycle imem_we=0, busy=0, inst_count=0. With INST_ASM_CHECKSUM_EN: SLL r2,r1,4 then MFHI r5 → checksum = 0x00011100 ^ 0x00002810 = 0x00013910.
